// File: rtl/counter_updown_mod.sv
// Parametrised modulo-N up/down counter with parallel load, terminal count and a
// registered wrap pulse; cascade stages by feeding tc into the next stage's en.
module counter_updown_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clearb,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
    $error("counter_updown_mod: illegal WIDTH/MODULUS combination");
  end

  // One extra bit so MODULUS == 2**WIDTH is representable for the load clamp.
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_q == LP_MAX);
  assign w_at_zero = (r_q == '0);

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_q_nxt = ({1'b0, d} < LP_MOD) ? d : LP_MAX;
    end else if (en) begin
      if (up) begin
        if (w_at_max) begin
          w_q_nxt    = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_q_nxt = r_q + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
          w_q_nxt    = LP_MAX;
          w_wrap_nxt = 1'b1;
        end else begin
          w_q_nxt = r_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clearb) begin
    if (!clearb) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign q    = r_q;
  assign qb   = ~r_q;
  assign wrap = r_wrap;
  assign tc   = en & ((up & w_at_max) | (~up & w_at_zero));

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: mod-16 and mod-10 counters plus a mod-10/mod-6
// cascade, all sharing stimulus, checked against integer count models.
module tb_counter_updown_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clearb, en, up, load;
  logic [3:0] d;
  logic [3:0] q16, qb16, q10, qb10, qlo, qblo, qhi, qbhi;
  logic       tc16, w16, tc10, w10, tclo, wlo, tchi, whi;

  counter_updown_mod #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .clk(clk), .clearb(clearb), .en(en), .up(up), .load(load), .d(d),
    .q(q16), .qb(qb16), .tc(tc16), .wrap(w16));

  counter_updown_mod #(.WIDTH(4), .MODULUS(10)) u_m10 (
    .clk(clk), .clearb(clearb), .en(en), .up(up), .load(load), .d(d),
    .q(q10), .qb(qb10), .tc(tc10), .wrap(w10));

  counter_updown_mod #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .clearb(clearb), .en(en), .up(up), .load(load), .d(d),
    .q(qlo), .qb(qblo), .tc(tclo), .wrap(wlo));

  counter_updown_mod #(.WIDTH(4), .MODULUS(6)) u_hi (
    .clk(clk), .clearb(clearb), .en(tclo), .up(up), .load(load), .d(d),
    .q(qhi), .qb(qbhi), .tc(tchi), .wrap(whi));

  int nvec = 0;
  int nerr = 0;

  // Reference state: plain counts; the cascade is one seconds value 0..59.
  int mq16, mq10, mc;
  int mw16, mw10, mwlo, mwhi;

  typedef struct {
    bit ld;
    bit e;
    bit u;
    int dv;
    int etc;
    int eq;
    int ew;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int dv, input int m);
    return (dv < m) ? dv : m - 1;
  endfunction

  function automatic int tc_of(input int cnt, input int m, input bit e, input bit u);
    return (e && (u ? (cnt == m - 1) : (cnt == 0))) ? 1 : 0;
  endfunction

  task automatic model_single(inout int mq, inout int mw, input int m,
                              input bit ld, input bit e, input bit u, input int dv);
    if (ld) begin
      mq = clampv(dv, m);
      mw = 0;
    end else if (e) begin
      mw = (u ? (mq == m - 1) : (mq == 0)) ? 1 : 0;
      mq = u ? (mq + 1) % m : (mq + m - 1) % m;
    end else begin
      mw = 0;
    end
  endtask

  task automatic model_step(input bit ld, input bit e, input bit u, input int dv);
    model_single(mq16, mw16, 16, ld, e, u, dv);
    model_single(mq10, mw10, 10, ld, e, u, dv);
    if (ld) begin
      mc   = clampv(dv, 6) * 10 + clampv(dv, 10);
      mwlo = 0;
      mwhi = 0;
    end else if (e) begin
      mwlo = (u ? (mc % 10 == 9) : (mc % 10 == 0)) ? 1 : 0;
      mwhi = (u ? (mc == 59) : (mc == 0)) ? 1 : 0;
      mc   = u ? (mc + 1) % 60 : (mc + 59) % 60;
    end else begin
      mwlo = 0;
      mwhi = 0;
    end
  endtask

  task automatic model_reset();
    mq16 = 0; mq10 = 0; mc = 0;
    mw16 = 0; mw10 = 0; mwlo = 0; mwhi = 0;
  endtask

  task automatic chk_state();
    chk("q16", q16, mq16);    chk("qb16", qb16, 15 - mq16);   chk("wrap16", w16, mw16);
    chk("q10", q10, mq10);    chk("qb10", qb10, 15 - mq10);   chk("wrap10", w10, mw10);
    chk("qlo", qlo, mc % 10); chk("qblo", qblo, 15 - mc % 10); chk("wraplo", wlo, mwlo);
    chk("qhi", qhi, mc / 10); chk("qbhi", qbhi, 15 - mc / 10); chk("wraphi", whi, mwhi);
  endtask

  task automatic chk_tc();
    chk("tc16", tc16, tc_of(mq16, 16, en, up));
    chk("tc10", tc10, tc_of(mq10, 10, en, up));
    chk("tclo", tclo, tc_of(mc % 10, 10, en, up));
    chk("tchi", tchi, (tc_of(mc % 10, 10, en, up) != 0 && tc_of(mc / 10, 6, 1'b1, up) != 0) ? 1 : 0);
  endtask

  // Drive one cycle of inputs away from the edge, check tc, clock, check state.
  task automatic apply(input bit ld, input bit e, input bit u, input int dv, output int tc10_pre);
    load = ld; en = e; up = u; d = 4'(dv);
    #1;
    chk_tc();
    tc10_pre = tc10;
    @(posedge clk);
    model_step(ld, e, u, dv);
    #1;
    chk_state();
  endtask

  task automatic async_clear();
    clearb = 1'b0;
    #1;
    model_reset();
    chk_state();
  endtask

  task automatic release_clear();
    @(negedge clk);
    clearb = 1'b1;
  endtask

  int t;
  int hi_wraps;
  int hi_wrap_at;

  initial begin
    clearb = 1'b0; en = 1'b1; up = 1'b0; load = 1'b0; d = '0;
    model_reset();
    #2;
    chk_state();
    chk("tc_rst_down", tc16, 1);
    up = 1'b1;
    #1;
    chk("tc_rst_up", tc16, 0);
    release_clear();

    // Count to 9, then clear asynchronously between edges.
    for (int i = 0; i < 9; i++) apply(1'b0, 1'b1, 1'b1, 0, t);
    chk("q16_before_clear", q16, 9);
    #2;
    async_clear();
    chk("clr_q16", q16, 0);
    chk("clr_qb16", qb16, 15);
    chk("clr_wrap16", w16, 0);
    release_clear();
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 1'b0, 0, t);
    chk("hold_q16", q16, 0);

    // Table of mod-10 cycles: tc before the edge, q and wrap after it.
    for (int i = 0; i < 12; i++)
      tbl.push_back('{1'b0, 1'b1, 1'b1, 0, (i == 9) ? 1 : 0, (i + 1) % 10, (i == 9) ? 1 : 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2,  0, 2, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 0,  0, 1, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 0,  0, 0, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 0,  1, 9, 1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 0,  0, 8, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 7,  0, 7, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 12, 0, 9, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 12, 1, 9, 0});
    foreach (tbl[i]) begin
      apply(tbl[i].ld, tbl[i].e, tbl[i].u, tbl[i].dv, t);
      chk($sformatf("tbl%0d_tc", i), t, tbl[i].etc);
      chk($sformatf("tbl%0d_q", i), q10, tbl[i].eq);
      chk($sformatf("tbl%0d_wrap", i), w10, tbl[i].ew);
    end

    // Direction flip across the mod-16 boundary.
    apply(1'b1, 1'b0, 1'b0, 14, t); chk("flip_load", q16, 14);
    apply(1'b0, 1'b1, 1'b1, 0, t);  chk("flip_q15", q16, 15); chk("flip_w0", w16, 0);
    apply(1'b0, 1'b1, 1'b1, 0, t);  chk("flip_q0", q16, 0);   chk("flip_w1", w16, 1);
    apply(1'b0, 1'b1, 1'b0, 0, t);  chk("flip_back", q16, 15); chk("flip_w2", w16, 1);
    apply(1'b0, 1'b0, 1'b0, 0, t);  chk("flip_hold", q16, 15); chk("flip_w3", w16, 0);
    chk("flip_tc_off", tc16, 0);

    // Cascade as a seconds counter: 60 clocks return to 00 with one high wrap.
    #2;
    async_clear();
    release_clear();
    hi_wraps = 0;
    hi_wrap_at = -1;
    for (int i = 0; i < 60; i++) begin
      apply(1'b0, 1'b1, 1'b1, 0, t);
      chk("cas_count", qhi * 10 + qlo, (i + 1) % 60);
      if (whi) begin
        hi_wraps++;
        hi_wrap_at = i + 1;
      end
    end
    chk("cas_hi_wraps", hi_wraps, 1);
    chk("cas_hi_wrap_clk", hi_wrap_at, 60);
    chk("cas_final_lo", qlo, 0);
    chk("cas_final_hi", qhi, 0);

    // Random stimulus with occasional asynchronous clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) begin
        #2;
        async_clear();
        release_clear();
      end
      apply(($urandom_range(7) == 0), ($urandom_range(3) != 0), $urandom_range(1) != 0,
            int'($urandom_range(15)), t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got time %0t, expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised synchronous modulo-N up/down counter; generalises the team's 4-bit synchronous binary counter.
- Adds configurable width and modulus, direction control, count enable, parallel load, terminal-count flag and registered wrap pulse.
- Serves as the standard counting primitive for Lab datapaths: dividers, sequencers, BCD digits when MODULUS=10.
- Cascadable: tc of one stage drives en of the next.

Parameters:
WIDTH, 4, counter width in bits; legal range 1..16.
MODULUS, 16, count sequence is 0..MODULUS-1; legal range 2..2**WIDTH; illegal values stop elaboration with an error.

Ports:
clk  input  1  rising-edge clock; single clock domain.
clearb  input  1  asynchronous active-low clear.
en  input  1  count enable, sampled on rising clk.
up  input  1  direction: 1 = increment, 0 = decrement.
load  input  1  synchronous parallel load, priority over en.
d  input  WIDTH  parallel load value.
q  output  WIDTH  registered count.
qb  output  WIDTH  bitwise complement of q, always ~q.
tc  output  1  combinational terminal count.
wrap  output  1  registered one-cycle pulse after a wrap-around.

Behaviour:
- Reset: clearb low forces, immediately and independent of clk, q=0, qb=all ones, wrap=0.
- tc during reset follows its rule with q=0: 1 if en=1 and up=0, else 0.
- Release: first active edge is the first rising clk with clearb high. Mid-operation reset discards the count and any pending wrap.
- Per rising clk, priority is load > en > hold.
- load=1: q <= d if d < MODULUS, else q <= MODULUS-1 (saturating clamp). wrap <= 0. en and up ignored.
- load=0, en=1, up=1: q <= q+1 when q < MODULUS-1; else q <= 0 and wrap <= 1.
- load=0, en=1, up=0: q <= q-1 when q > 0; else q <= MODULUS-1 and wrap <= 1.
- All other cycles: q holds, wrap <= 0. wrap is high for exactly one cycle per wrap event.
- Latency: one clk from sampled control to updated q.
- tc = en & ((up & q==MODULUS-1) | (~up & q==0)). tc is purely combinational, with no registered delay.
- Cascading: stage n+1 en = stage n tc, with shared clk, up and clearb. The chain must count as a single modulo-(product of moduli) counter.
- Direction change takes effect on the same edge it is sampled; there is no turnaround cycle.
- Arithmetic is internal to WIDTH bits.
  - No intermediate value may exceed MODULUS-1.
  - When MODULUS=2**WIDTH, natural overflow and underflow give the same result as the explicit wrap.
- q never holds a value >= MODULUS in any reachable state, including after a clamped load.
- Implementation style (behavioural or JK/T flip-flop structural) is free, provided q/qb/tc/wrap behaviour is cycle-identical to this description.

Test Plan:
1. Reset and hold: WIDTH=4, MODULUS=16, clearb low mid-count at q=9 -> q=0, qb=4'hF, wrap=0 immediately without a clk edge. Hold clearb high with en=0 for 5 clks -> q stays 0.
2. Up wrap: MODULUS=10, en=1, up=1 from 0 for 12 clks.
   - q runs 0..9,0,1,2.
   - tc=1 only while q=9.
   - wrap=1 only in the cycle where q=0 after 9.
3. Down wrap: MODULUS=10, load d=2, then en=1, up=0 for 4 clks.
   - q runs 2,1,0,9,8.
   - tc=1 while q=0.
   - wrap pulses once, coincident with q=9.
4. Load priority and clamp:
   - load=1, en=1, d=7 -> q=7 next clk, no count.
   - load=1, d=4'hC with MODULUS=10 -> q=9.
   - load=1 at q=9 with up=1 -> wrap stays 0.
5. Direction flip: MODULUS=16, q=14.
   - up=1 for 2 clks -> q runs 15 then 0, wrap pulse.
   - Then up=0 -> q=15, wrap pulse again.
   - Then en=0 -> q holds 15, tc=0.
6. Cascade: two instances with MODULUS=10 and MODULUS=6 (seconds counter), low tc driving high en, en=1, up=1 for 60 clks.
   - Count sequence 00..59 then 00.
   - High-stage wrap asserts exactly once, after clk 60.
